// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the pipelined MIPS core.
// Captures the decoded control word and operands, and detects load-use
// hazards, inserting a one-cycle bubble for each one. A flush resolved
// in EX squashes the decode instruction. Saturating counters track how
// many stall and flush events have occurred, for performance debug.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_regwrite,
  input  logic              id_regdst,
  input  logic              id_alusrc,
  input  logic              id_branch,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_jump,
  input  logic              id_b,
  input  logic [3:0]        id_aluctrl,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_regdst,
  output logic              ex_alusrc,
  output logic              ex_branch,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_jump,
  output logic              ex_b,
  output logic [3:0]        ex_aluctrl,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [4:0]        ex_shamt,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic id_uses_rt;
  logic hazard;
  logic take;

  // Load-use detection: a load in EX whose destination feeds the decode
  // instruction. Register $0 never carries a dependency.
  always_comb begin
    id_uses_rt = id_regdst | id_memwrite | id_branch;
    hazard     = ex_valid & ex_memtoreg & ex_regwrite & (ex_rt != 5'd0) & id_valid &
                 ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    stall      = hazard & ~flush;
    // Control is only passed on for a real, unsquashed, unstalled instruction.
    // Gating with AND keeps unknown control-unit outputs out of EX.
    take       = id_valid & ~flush & ~stall;
  end

  // Control word register: a bubble (all zero) unless a real instruction advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_regdst   <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_branch   <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_jump     <= 1'b0;
      ex_b        <= 1'b0;
      ex_aluctrl  <= 4'd0;
    end else begin
      ex_valid    <= take;
      ex_regwrite <= take & id_regwrite;
      ex_regdst   <= take & id_regdst;
      ex_alusrc   <= take & id_alusrc;
      ex_branch   <= take & id_branch;
      ex_memwrite <= take & id_memwrite;
      ex_memtoreg <= take & id_memtoreg;
      ex_jump     <= take & id_jump;
      ex_b        <= take & id_b;
      ex_aluctrl  <= id_aluctrl & {4{take}};
    end
  end

  // Datapath register: loads every cycle, so bubbles still carry defined values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_pc4   <= '0;
      ex_shamt <= 5'd0;
      ex_rs    <= 5'd0;
      ex_rt    <= 5'd0;
      ex_rd    <= 5'd0;
    end else begin
      ex_rd1   <= id_rd1;
      ex_rd2   <= id_rd2;
      ex_imm   <= id_imm;
      ex_pc4   <= id_pc4;
      ex_shamt <= id_shamt;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
    end
  end

  // Saturating event counters; a clear overrides a simultaneous increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the stage.
module tb_id_ex_stage;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic        valid;
    logic [7:0]  ctrl;   // regwrite,regdst,alusrc,branch,memwrite,memtoreg,jump,b
    logic [3:0]  alu;
    logic [31:0] rd1, rd2, imm, pc4;
    logic [4:0]  shamt, rs, rt, rd;
  } word_t;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_regwrite, id_regdst, id_alusrc, id_branch;
  logic id_memwrite, id_memtoreg, id_jump, id_b;
  logic [3:0] id_aluctrl;
  logic [DATA_W-1:0] id_rd1, id_rd2, id_imm, id_pc4;
  logic [4:0] id_shamt, id_rs, id_rt, id_rd;
  logic flush, cnt_clr;
  logic stall, ex_valid, ex_regwrite, ex_regdst, ex_alusrc, ex_branch;
  logic ex_memwrite, ex_memtoreg, ex_jump, ex_b;
  logic [3:0] ex_aluctrl;
  logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
  logic [4:0] ex_shamt, ex_rs, ex_rt, ex_rd;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_regwrite(id_regwrite), .id_regdst(id_regdst), .id_alusrc(id_alusrc),
    .id_branch(id_branch), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .id_jump(id_jump), .id_b(id_b), .id_aluctrl(id_aluctrl),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_shamt(id_shamt),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_pc4(id_pc4),
    .flush(flush), .cnt_clr(cnt_clr), .stall(stall), .ex_valid(ex_valid),
    .ex_regwrite(ex_regwrite), .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc),
    .ex_branch(ex_branch), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_jump(ex_jump), .ex_b(ex_b), .ex_aluctrl(ex_aluctrl),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .ex_shamt(ex_shamt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  word_t m = '{default: '0};
  int    m_scnt = 0;
  int    m_fcnt = 0;

  function automatic bit m_stall();
    bit uses_rt, is_load, dep;
    uses_rt = (id_regdst === 1'b1) || (id_memwrite === 1'b1) || (id_branch === 1'b1);
    is_load = m.valid && m.ctrl[7] && m.ctrl[2] && (m.rt != 0);
    dep     = (m.rt == id_rs) || (uses_rt && (m.rt == id_rt));
    return is_load && (id_valid === 1'b1) && dep && (flush !== 1'b1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m = '{default: '0};
      m_scnt = 0;
      m_fcnt = 0;
    end else begin
      bit s, adv;
      s   = m_stall();
      adv = (flush !== 1'b1) && !s && (id_valid === 1'b1);
      m.valid = adv;
      m.ctrl  = adv ? {id_regwrite, id_regdst, id_alusrc, id_branch,
                       id_memwrite, id_memtoreg, id_jump, id_b} : 8'h00;
      m.alu   = adv ? id_aluctrl : 4'h0;
      m.rd1 = id_rd1; m.rd2 = id_rd2; m.imm = id_imm; m.pc4 = id_pc4;
      m.shamt = id_shamt; m.rs = id_rs; m.rt = id_rt; m.rd = id_rd;
      if (cnt_clr) begin
        m_scnt = 0;
        m_fcnt = 0;
      end else begin
        if (s && m_scnt < CNT_MAX) m_scnt++;
        if (flush && m_fcnt < CNT_MAX) m_fcnt++;
      end
    end
  end

  // Compare DUT against the model mid-cycle, every cycle.
  always @(negedge clk) begin
    chk("ctrl_word", {ex_valid, ex_regwrite, ex_regdst, ex_alusrc, ex_branch,
                      ex_memwrite, ex_memtoreg, ex_jump, ex_b, ex_aluctrl},
                     {m.valid, m.ctrl, m.alu});
    chk("ex_rd1", ex_rd1, m.rd1);
    chk("ex_rd2", ex_rd2, m.rd2);
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_pc4", ex_pc4, m.pc4);
    chk("ex_fields", {ex_shamt, ex_rs, ex_rt, ex_rd}, {m.shamt, m.rs, m.rt, m.rd});
    chk("stall", stall, m_stall());
    chk("stall_cnt", stall_cnt, m_scnt);
    chk("flush_cnt", flush_cnt, m_fcnt);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input word_t w, input logic fl, input logic clr);
    id_valid = w.valid;
    {id_regwrite, id_regdst, id_alusrc, id_branch,
     id_memwrite, id_memtoreg, id_jump, id_b} = w.ctrl;
    id_aluctrl = w.alu;
    id_rd1 = w.rd1; id_rd2 = w.rd2; id_imm = w.imm; id_pc4 = w.pc4;
    id_shamt = w.shamt; id_rs = w.rs; id_rt = w.rt; id_rd = w.rd;
    flush = fl;
    cnt_clr = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic word_t mk(input logic v, input logic [7:0] c, input logic [3:0] a,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    word_t w;
    w.valid = v; w.ctrl = c; w.alu = a;
    w.rd1 = $urandom; w.rd2 = $urandom; w.imm = $urandom; w.pc4 = $urandom;
    w.shamt = 5'($urandom); w.rs = rs; w.rt = rt; w.rd = rd;
    return w;
  endfunction

  function automatic word_t rnd();
    word_t w;
    w = mk(($urandom_range(0, 9) < 8), 8'($urandom), 4'($urandom),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    if ($urandom_range(0, 2) == 0) w.ctrl[7] = 1'b1;
    return w;
  endfunction

  localparam logic [7:0] C_ADD  = 8'b1100_0000;  // regwrite, regdst
  localparam logic [7:0] C_LW   = 8'b1010_0100;  // regwrite, alusrc, memtoreg
  localparam logic [7:0] C_ADDI = 8'b1010_0000;  // regwrite, alusrc

  initial begin
    word_t w;
    int    fbase;

    rst_n = 1'b0;
    drive(mk(1'b0, 8'h00, 4'h0, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0);
    repeat (3) step();
    chk("reset_ex_valid", ex_valid, 1'b0);
    chk("reset_stall_cnt", stall_cnt, 0);
    rst_n = 1'b1;

    // Idle slot with unknown control bits: nothing may reach EX.
    w = mk(1'b0, 8'h00, 4'h0, 5'd0, 5'd0, 5'd0);
    drive(w, 1'b0, 1'b0);
    {id_regwrite, id_regdst, id_alusrc, id_branch, id_memwrite, id_memtoreg, id_jump, id_b} = 'x;
    id_aluctrl = 'x;
    step();
    chk("idle_ctrl", {ex_regwrite, ex_memtoreg, ex_aluctrl}, 6'd0);

    // R-type passthrough.
    w = mk(1'b1, C_ADD, 4'b0000, 5'd1, 5'd2, 5'd3);
    w.rd1 = 32'h5; w.rd2 = 32'h7;
    drive(w, 1'b0, 1'b0);
    step();
    chk("add_valid", ex_valid, 1'b1);
    chk("add_rd1", ex_rd1, 32'h5);
    chk("add_rd2", ex_rd2, 32'h7);
    chk("add_regs", {ex_rs, ex_rt, ex_rd}, {5'd1, 5'd2, 5'd3});

    // Load-use: LW to $4 then ADD reading $4.
    drive(mk(1'b1, C_LW, 4'b0010, 5'd9, 5'd4, 5'd0), 1'b0, 1'b0);
    step();
    drive(mk(1'b1, C_ADD, 4'b0000, 5'd4, 5'd6, 5'd7), 1'b0, 1'b0);
    #1 chk("lu_stall", stall, 1'b1);
    step();
    chk("lu_bubble", {ex_valid, ex_regwrite}, 2'b00);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_stall_clears", stall, 1'b0);
    step();
    chk("lu_add_captured", {ex_valid, ex_rs}, {1'b1, 5'd4});

    // No false hazard: load into $0, then an ADDI that only writes rt.
    drive(mk(1'b1, C_LW, 4'b0010, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0);
    step();
    drive(mk(1'b1, C_ADD, 4'b0000, 5'd0, 5'd0, 5'd8), 1'b0, 1'b0);
    #1 chk("zero_no_stall", stall, 1'b0);
    step();
    drive(mk(1'b1, C_LW, 4'b0010, 5'd1, 5'd5, 5'd0), 1'b0, 1'b0);
    step();
    drive(mk(1'b1, C_ADDI, 4'b0010, 5'd1, 5'd5, 5'd0), 1'b0, 1'b0);
    #1 chk("addi_no_stall", stall, 1'b0);
    step();

    // Flush beats a simultaneous load-use hazard.
    drive(mk(1'b1, C_LW, 4'b0010, 5'd1, 5'd6, 5'd0), 1'b0, 1'b0);
    step();
    fbase = int'(flush_cnt);
    drive(mk(1'b1, C_ADD, 4'b0000, 5'd6, 5'd2, 5'd3), 1'b1, 1'b0);
    #1 chk("flush_no_stall", stall, 1'b0);
    step();
    chk("flush_bubble", ex_valid, 1'b0);
    chk("flush_cnt_inc", flush_cnt, fbase + 1);
    chk("flush_stall_cnt_hold", stall_cnt, 1);

    // Saturation, then clear winning over a simultaneous flush.
    for (int i = 0; i < 20; i++) begin
      drive(rnd(), 1'b1, 1'b0);
      step();
    end
    chk("flush_sat", flush_cnt, CNT_MAX);
    drive(rnd(), 1'b1, 1'b1);
    step();
    chk("clr_wins", {stall_cnt, flush_cnt}, 8'd0);

    // Randomized traffic, checked by the per-cycle compare.
    for (int i = 0; i < 2000; i++) begin
      drive(rnd(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
      step();
    end

    // Asynchronous reset in the middle of a stall.
    drive(mk(1'b1, C_LW, 4'b0010, 5'd1, 5'd3, 5'd0), 1'b0, 1'b0);
    step();
    drive(mk(1'b1, C_ADD, 4'b0000, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0);
    #1 chk("pre_reset_stall", stall, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_ctrl", {ex_valid, ex_regwrite, ex_memtoreg, ex_aluctrl}, 7'd0);
    chk("async_data", {ex_rd1, ex_rt}, 37'd0);
    chk("async_stall", stall, 1'b0);
    chk("async_cnts", {stall_cnt, flush_cnt}, 8'd0);
    step();
    rst_n = 1'b1;
    drive(mk(1'b0, 8'h00, 4'h0, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the pipelined MIPS core. It sits directly downstream of the decode-stage control unit.
- Registers the decoded control word (RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, Jump, B, ALUControl) together with the decode datapath operands.
- Performs load-use hazard detection and bubble insertion, and squashes the instruction on an EX-resolved branch/jump flush.
- Keeps saturating stall/flush event counters for performance debug.

Parameters:
DATA_W, 32, width of register operands, immediate and PC+4
CNT_W, 16, width of stall/flush event counters

Ports:
clk  in  1  clock, all state rising-edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode stage holds a real instruction
id_regwrite, id_regdst, id_alusrc, id_branch, id_memwrite, id_memtoreg, id_jump, id_b  in  1 each  control bits from the control unit
id_aluctrl  in  4  ALU operation code from the control unit
id_rd1, id_rd2  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign-extended immediate
id_shamt  in  5  shift amount
id_rs, id_rt, id_rd  in  5 each  register specifiers
id_pc4  in  DATA_W  PC+4 of the decode instruction
flush  in  1  EX has resolved a taken branch/jump; squash the decode instruction
cnt_clr  in  1  synchronous clear of both counters
stall  out  1  combinational; hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
ex_regwrite, ex_regdst, ex_alusrc, ex_branch, ex_memwrite, ex_memtoreg, ex_jump, ex_b  out  1 each  registered control bits
ex_aluctrl  out  4  registered ALU operation code
ex_rd1, ex_rd2, ex_imm, ex_pc4  out  DATA_W  registered operands
ex_shamt, ex_rs, ex_rt, ex_rd  out  5 each  registered fields
stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output and both counters go to 0. stall reads 0 because ex_valid=0.
- Rising edges: ignored while rst_n=0. The first capture is on the first rising edge after deassertion.
- id_uses_rt = id_regdst | id_memwrite | id_branch.
- hazard = ex_valid & ex_memtoreg & ex_regwrite & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- stall = hazard & ~flush. Purely combinational, with no registered delay.
- Per clock edge, three cases, in priority order:
  1. flush=1: capture a bubble.
  2. else stall=1: capture a bubble.
  3. else: capture the decode word, with ex_valid = id_valid.
- Bubble: ex_valid=0 and all ex control bits and ex_aluctrl = 0. Datapath fields (rd1, rd2, imm, shamt, rs, rt, rd, pc4) still load the id_* values, so there are no X values downstream.
- id_valid=0: control bits and ex_aluctrl are captured as 0 regardless of their values. The default control-unit output of X for unknown opcodes must never reach EX.
- Latency: exactly 1 cycle from id_* to ex_*. A stall lasts exactly one cycle per load-use pair, because the following edge turns EX into a bubble and clears the hazard.
- Flush and hazard in the same cycle: flush wins. stall=0, no stall count, flush counted.
- Counters:
  - stall_cnt increments on each edge where stall=1.
  - flush_cnt increments on each edge where flush=1.
  - Both saturate at 2^CNT_W-1, with no wrap-around.
  - cnt_clr=1 forces both to 0 on that edge; clear wins over a simultaneous increment.
- $zero: ex_rt=0 never creates a hazard, even for a load into $0.
- Reset mid-operation: the pipeline is emptied immediately and no partial state is retained.

Test Plan:
- Reset then idle: rst_n low 3 cycles, id_valid=0 → all ex_* = 0, stall=0, counters 0. After release, one edge with id_valid=0 and control inputs X → ex control still 0.
- R-type passthrough: id_valid=1, ADD control (regwrite=1, regdst=1, aluctrl=0000), rd1=0x5, rd2=0x7, rs=1, rt=2, rd=3 → next edge ex_* match exactly, ex_valid=1, stall=0.
- Load-use: LW into rt=4 captured, then decode holds ADD with rs=4 → stall=1 that cycle, next edge EX is a bubble (ex_valid=0, ex_regwrite=0), stall_cnt=1. The following edge captures the ADD.
- No false hazard: LW to rt=0 followed by rs=0; separately, LW to rt=5 followed by ADDI with rt=5 (id_uses_rt=0) → stall=0 in both cases.
- Flush priority: load-use hazard present and flush=1 in the same cycle → stall=0, EX is a bubble, flush_cnt +1, stall_cnt unchanged.
- Counter saturation/clear: CNT_W=4, 20 consecutive flush cycles → flush_cnt=15 and holds. cnt_clr and flush asserted together → flush_cnt=0. Async reset mid-stall → all outputs 0 immediately, without waiting for an edge.
